mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, three-slave memory bus controller between the core and its on-chip targets. Accepts requests from the instruction-fetch port and the load/store port and serializes them onto one shared slave bus, one transaction at a time. Decodes each address to BRAM, UART or CLINT and returns a zero-data error response for unmapped addresses. Sits between the core/prefetch unit and the BRAM, UART and CLINT blocks in the SoC top.

## Interface

Parameters:
- bram_depth, 12: BRAM word-address width; BRAM spans start_base_addr .. start_base_addr + 2^(bram_depth+2) - 1.
- start_base_addr, 32'h0: BRAM base.
- uart_base_addr / uart_top_addr, 32'h100000 / 32'h100004: UART window [base, top).
- clint_base_addr / clint_top_addr, 32'h2000000 / 32'h200C000: CLINT window [base, top).

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_valid  in  1  fetch request pulse; 1 cycle is sufficient.
- imem_addr  in  32  fetch byte address.
- imem_rdata  out  32  fetch read data, valid with imem_ready.
- imem_ready  out  1  single-cycle completion pulse.
- dmem_valid  in  1  load/store request pulse.
- dmem_addr  in  32  load/store byte address.
- dmem_wdata  in  32  store data.
- dmem_wstrb  in  4  byte enables; 0 = read.
- dmem_rdata  out  32  load data, valid with dmem_ready.
- dmem_ready  out  1  single-cycle completion pulse.
- slave_valid  out  3  one-hot select; [0] BRAM, [1] UART, [2] CLINT.
- slave_addr  out  32  latched address, offset not subtracted.
- slave_wdata  out  32  latched write data (0 for fetch).
- slave_wstrb  out  4  latched strobes (0 for fetch).
- slave_rdata  in  96  packed read data; [31:0] BRAM, [63:32] UART, [95:64] CLINT.
- slave_ready  in  3  per-slave completion, same bit order.
- bus_error  out  1  single-cycle pulse when an unmapped access completes.

## Operation

- Per-master pending flag plus latched addr/wdata/wstrb. Flag is set when valid is high. Flag is cleared when that master's transaction is granted. Valid is never lost, even when it arrives while BUSY or in the cycle the master's own ready fires.
- A request is pending if the flag is set or valid is high this cycle. Combinational bypass: a valid seen in IDLE is granted the same cycle.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: if any request is pending, choose a winner per arbitration policy and register it: grant owner, decoded slave index, addr, wdata, wstrb. Go to BUSY if the address is mapped, else RESP.
  - BUSY: drive slave_valid one-hot and hold it until the selected slave_ready bit is sampled high. At that edge, register the selected rdata into the owner's rdata, pulse the owner's ready the next cycle, and go to IDLE.
  - RESP (unmapped): next cycle pulse the owner's ready with rdata = 0 and pulse bus_error; go to IDLE.
- slave_ready bits of non-selected slaves are ignored.
- Decode is evaluated on the latched address only. Windows are half-open [base, top). Comparisons are 32-bit unsigned. Decode priority on overlap: BRAM > UART > CLINT.
- Fetch requests always drive wstrb = 0 and wdata = 0.
- Asynchronous reset, at any time including mid-transaction: go to IDLE and clear pending flags, latches, last-grant and rdata registers. All outputs are 0 during and after reset. Aborted transactions are not replayed.

## Timing

- Cycle 0: valid in IDLE, so grant.
- Cycle 1: slave_valid high.
- Slave responds at cycle k ≥ 1, so master ready is at cycle k+1. Minimum latency is 2 cycles.
- Unmapped access: ready and bus_error at cycle 2.
- Back-to-back: ready in cycle n, then IDLE in cycle n allows the next grant in cycle n. Throughput is one transaction per (slave latency + 1) cycles.
- Exactly one of imem_ready / dmem_ready fires per transaction; they are never high together.

## Configuration

- MEM_ARBITER_ROUND_ROBIN_EN defined:
  - When both masters are pending in IDLE, grant the master not granted last.
  - The last-grant register resets to imem, so dmem wins the first tie.
- Not defined: fixed priority; dmem always wins a tie. The last-grant register is not implemented.

## Test plan

- Single fetch, imem_addr=0x10, BRAM ready at cycle 2 with rdata 0xDEADBEEF -> slave_valid=3'b001 in cycles 1–2; imem_ready and imem_rdata=0xDEADBEEF at cycle 3.
- Simultaneous imem_valid (0x0) and dmem_valid (0x100000, wstrb=4'h1, wdata=0x41) pulses, slaves respond in 1 cycle -> dmem served first via UART (slave_valid=3'b010). imem is then served from its pending flag without re-asserting valid.
- Repeated simultaneous requests: with the macro the grants alternate d,i,d,i; without the macro the grants are d every time.
- dmem read of 0x3000000 -> no slave_valid; dmem_ready, dmem_rdata=0 and bus_error at cycle 2.
- Read of 0x200BFF8 -> CLINT selected. Read of 0x200C000 -> unmapped. Read of 0x3FFC (bram_depth=12) -> BRAM.
- reset asserted low while BUSY, with a pending imem request -> all outputs 0 immediately. After release no ready fires, and the next valid is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (fetch, load/store) to three-slave (BRAM, UART, CLINT) bus arbiter.
// Optional round-robin tie-break: define MEM_ARBITER_ROUND_ROBIN_EN; otherwise dmem wins ties.
module mem_arbiter #(
   parameter int unsigned bram_depth      = 12,
   parameter logic [31:0] start_base_addr = 32'h0,
   parameter logic [31:0] uart_base_addr  = 32'h0010_0000,
   parameter logic [31:0] uart_top_addr   = 32'h0010_0004,
   parameter logic [31:0] clint_base_addr = 32'h0200_0000,
   parameter logic [31:0] clint_top_addr  = 32'h0200_C000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        imem_valid,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_rdata,
   output logic        imem_ready,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_rdata,
   output logic        dmem_ready,
   output logic [2:0]  slave_valid,
   output logic [31:0] slave_addr,
   output logic [31:0] slave_wdata,
   output logic [3:0]  slave_wstrb,
   input  logic [95:0] slave_rdata,
   input  logic [2:0]  slave_ready,
   output logic        bus_error
);
   // state | meaning
   // IDLE  | waiting for a request; grants in the same cycle a valid is seen
   // BUSY  | slave_valid held until the selected slave_ready bit is sampled
   // RESP  | unmapped address; next cycle returns zero data with bus_error
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [32:0] bram_lo = {1'b0, start_base_addr};
   localparam logic [32:0] bram_hi = bram_lo + (33'd1 << (bram_depth + 2));

   state_t      state;
   logic        i_pend, d_pend;
   logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
   logic [3:0]  d_wstrb_q;
   logic        owner_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic        last_d;
`endif

   logic        i_req, d_req, grant_go, grant_d, gnt_i, gnt_d;
   logic [31:0] i_cur_addr, d_cur_addr, d_cur_wdata, g_addr, g_wdata, sel_rdata;
   logic [3:0]  d_cur_wstrb, g_wstrb;
   logic        in_bram, in_uart, in_clint;
   logic [2:0]  g_hit;

   assign i_req       = i_pend | imem_valid;
   assign d_req       = d_pend | dmem_valid;
   assign grant_go    = (state == IDLE) && (i_req || d_req);
   assign i_cur_addr  = i_pend ? i_addr_q : imem_addr;
   assign d_cur_addr  = d_pend ? d_addr_q : dmem_addr;
   assign d_cur_wdata = d_pend ? d_wdata_q : dmem_wdata;
   assign d_cur_wstrb = d_pend ? d_wstrb_q : dmem_wstrb;

   always_comb begin
      grant_d = d_req;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (i_req && d_req) grant_d = ~last_d;
`endif
   end

   assign gnt_i   = grant_go && !grant_d;
   assign gnt_d   = grant_go && grant_d;
   assign g_addr  = grant_d ? d_cur_addr : i_cur_addr;
   assign g_wdata = grant_d ? d_cur_wdata : 32'h0;
   assign g_wstrb = grant_d ? d_cur_wstrb : 4'h0;

   // 33-bit compare so a BRAM window ending at 2^32 cannot wrap
   assign in_bram  = ({1'b0, g_addr} >= bram_lo) && ({1'b0, g_addr} < bram_hi);
   assign in_uart  = (g_addr >= uart_base_addr) && (g_addr < uart_top_addr);
   assign in_clint = (g_addr >= clint_base_addr) && (g_addr < clint_top_addr);

   always_comb begin
      g_hit = 3'b000;
      if (in_bram)       g_hit = 3'b001;
      else if (in_uart)  g_hit = 3'b010;
      else if (in_clint) g_hit = 3'b100;
   end

   always_comb begin
      sel_rdata = slave_rdata[95:64];
      if (slave_valid[0])      sel_rdata = slave_rdata[31:0];
      else if (slave_valid[1]) sel_rdata = slave_rdata[63:32];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         i_pend      <= 1'b0;
         d_pend      <= 1'b0;
         i_addr_q    <= 32'h0;
         d_addr_q    <= 32'h0;
         d_wdata_q   <= 32'h0;
         d_wstrb_q   <= 4'h0;
         owner_d     <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_d      <= 1'b0;
`endif
         imem_rdata  <= 32'h0;
         imem_ready  <= 1'b0;
         dmem_rdata  <= 32'h0;
         dmem_ready  <= 1'b0;
         slave_valid <= 3'b000;
         slave_addr  <= 32'h0;
         slave_wdata <= 32'h0;
         slave_wstrb <= 4'h0;
         bus_error   <= 1'b0;
      end else begin
         imem_ready <= 1'b0;
         dmem_ready <= 1'b0;
         bus_error  <= 1'b0;

         // a new valid arriving while the old one is granted from the flag stays pending
         i_pend <= gnt_i ? (i_pend & imem_valid) : (i_pend | imem_valid);
         d_pend <= gnt_d ? (d_pend & dmem_valid) : (d_pend | dmem_valid);
         if (imem_valid && (!i_pend || gnt_i)) i_addr_q <= imem_addr;
         if (dmem_valid && (!d_pend || gnt_d)) begin
            d_addr_q  <= dmem_addr;
            d_wdata_q <= dmem_wdata;
            d_wstrb_q <= dmem_wstrb;
         end

         case (state)
            IDLE: begin
               if (grant_go) begin
                  owner_d     <= grant_d;
                  slave_addr  <= g_addr;
                  slave_wdata <= g_wdata;
                  slave_wstrb <= g_wstrb;
                  slave_valid <= g_hit;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                  last_d      <= grant_d;
`endif
                  state       <= (g_hit != 3'b000) ? BUSY : RESP;
               end
            end
            BUSY: begin
               if ((slave_ready & slave_valid) != 3'b000) begin
                  slave_valid <= 3'b000;
                  if (owner_d) begin
                     dmem_rdata <= sel_rdata;
                     dmem_ready <= 1'b1;
                  end else begin
                     imem_rdata <= sel_rdata;
                     imem_ready <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            RESP: begin
               if (owner_d) begin
                  dmem_rdata <= 32'h0;
                  dmem_ready <= 1'b1;
               end else begin
                  imem_rdata <= 32'h0;
                  imem_ready <= 1'b1;
               end
               bus_error <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural slaves with programmable latency and a
// response scoreboard; honours MEM_ARBITER_ROUND_ROBIN_EN for tie-break expectations.
module tb_mem_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic        imem_valid, dmem_valid;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] imem_rdata, dmem_rdata;
   logic        imem_ready, dmem_ready, bus_error;
   logic [2:0]  slave_valid, slave_ready;
   logic [31:0] slave_addr, slave_wdata;
   logic [3:0]  slave_wstrb;
   logic [95:0] slave_rdata;

   int total = 0;
   int bad   = 0;
   int lat   = 1;
   int scnt  = 0;
   logic noise = 1'b0;

   typedef struct {
      logic        dm;
      logic [31:0] rdata;
      logic        err;
      logic [2:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;
   exp_t sb[$];

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .slave_valid(slave_valid), .slave_addr(slave_addr), .slave_wdata(slave_wdata),
      .slave_wstrb(slave_wstrb), .slave_rdata(slave_rdata), .slave_ready(slave_ready),
      .bus_error(bus_error)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] rd_model(input logic [2:0] sel, input logic [31:0] a);
      case (sel)
         3'b001:  return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hB0B0_0000);
         3'b010:  return a ^ 32'h0A0A_0000;
         3'b100:  return a ^ 32'h00C0_C000;
         default: return 32'h0;
      endcase
   endfunction

   assign slave_rdata = {rd_model(3'b100, slave_addr), rd_model(3'b010, slave_addr), rd_model(3'b001, slave_addr)};

   // slaves: the selected one answers after lat cycles; noise raises the other ready bits
   always @(posedge clock) begin
      #1;
      if (slave_valid == 3'b000) scnt = 0;
      else scnt = scnt + 1;
      slave_ready = noise ? ~slave_valid : 3'b000;
      if (slave_valid != 3'b000 && scnt == lat) slave_ready = slave_ready | slave_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push_exp(input logic dm, input logic [2:0] sel, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wstrb);
      exp_t e;
      e.dm    = dm;
      e.sel   = sel;
      e.addr  = addr;
      e.wdata = dm ? wdata : 32'h0;
      e.wstrb = dm ? wstrb : 4'h0;
      e.rdata = rd_model(sel, addr);
      e.err   = (sel == 3'b000);
      sb.push_back(e);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
   endtask

   task automatic drive_i(input logic [31:0] a);
      imem_valid = 1'b1;
      imem_addr  = a;
   endtask

   task automatic drive_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      dmem_valid = 1'b1;
      dmem_addr  = a;
      dmem_wdata = wd;
      dmem_wstrb = ws;
   endtask

   // steps until a ready pulse; checks latency, owner, data, error and captured slave request
   task automatic wait_resp(input int exp_n, input string tag);
      int n;
      logic got;
      logic [2:0] seen;
      logic [31:0] ca, cw;
      logic [3:0] cs;
      exp_t e;
      n = 0; got = 1'b0; seen = 3'b000; ca = 32'h0; cw = 32'h0; cs = 4'h0;
      while (!got && n < 20) begin
         step();
         n++;
         if (slave_valid != 3'b000 && seen == 3'b000) begin
            ca = slave_addr;
            cw = slave_wdata;
            cs = slave_wstrb;
         end
         seen = seen | slave_valid;
         got  = imem_ready | dmem_ready;
      end
      chk({tag, ".got_ready"}, got, 1'b1);
      chk({tag, ".latency"}, n, exp_n);
      chk({tag, ".sb_nonempty"}, sb.size() != 0, 1'b1);
      if (got && sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, ".both_ready"}, imem_ready & dmem_ready, 1'b0);
         chk({tag, ".owner"}, dmem_ready, e.dm);
         chk({tag, ".rdata"}, e.dm ? dmem_rdata : imem_rdata, e.rdata);
         chk({tag, ".bus_error"}, bus_error, e.err);
         chk({tag, ".slave_sel"}, seen, e.sel);
         if (e.sel != 3'b000) chk({tag, ".slave_req"}, {ca, cw, cs}, {e.addr, e.wdata, e.wstrb});
      end
   endtask

   initial begin
      int quiet;
      reset = 1'b0;
      imem_valid = 1'b0; imem_addr = 32'h0;
      dmem_valid = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
      slave_ready = 3'b000;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outputs", {imem_rdata, imem_ready, dmem_rdata, dmem_ready, slave_valid,
                            slave_addr, slave_wdata, slave_wstrb, bus_error}, '0);
      reset = 1'b1;
      step();

      // single fetch, BRAM answers at cycle 2
      lat = 2;
      drive_i(32'h10);
      push_exp(1'b0, 3'b001, 32'h10, 32'h0, 4'h0);
      wait_resp(3, "fetch");

      // simultaneous: dmem to UART first, imem from its pending flag
      lat = 1;
      noise = 1'b1;
      drive_i(32'h0);
      drive_d(32'h0010_0000, 32'h41, 4'h1);
      push_exp(1'b1, 3'b010, 32'h0010_0000, 32'h41, 4'h1);
      push_exp(1'b0, 3'b001, 32'h0, 32'h0, 4'h0);
      wait_resp(2, "sim_d");
      wait_resp(2, "sim_i");

      // repeated tie: dmem re-requests in its own ready cycle while imem is still pending
      drive_i(32'h20);
      drive_d(32'h24, 32'h0, 4'h0);
      push_exp(1'b1, 3'b001, 32'h24, 32'h0, 4'h0);
      wait_resp(2, "tie_a");
      drive_d(32'h28, 32'h0, 4'h0);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      push_exp(1'b0, 3'b001, 32'h20, 32'h0, 4'h0);
      push_exp(1'b1, 3'b001, 32'h28, 32'h0, 4'h0);
`else
      push_exp(1'b1, 3'b001, 32'h28, 32'h0, 4'h0);
      push_exp(1'b0, 3'b001, 32'h20, 32'h0, 4'h0);
`endif
      wait_resp(2, "tie_b");
      wait_resp(2, "tie_c");

      // decode boundaries
      drive_d(32'h0300_0000, 32'h0, 4'h0);
      push_exp(1'b1, 3'b000, 32'h0300_0000, 32'h0, 4'h0);
      wait_resp(2, "unmapped_d");
      drive_d(32'h0200_BFF8, 32'h0, 4'h0);
      push_exp(1'b1, 3'b100, 32'h0200_BFF8, 32'h0, 4'h0);
      wait_resp(2, "clint_last");
      drive_i(32'h0200_C000);
      push_exp(1'b0, 3'b000, 32'h0200_C000, 32'h0, 4'h0);
      wait_resp(2, "clint_top");
      drive_d(32'h3FFC, 32'h1234_5678, 4'hF);
      push_exp(1'b1, 3'b001, 32'h3FFC, 32'h1234_5678, 4'hF);
      wait_resp(2, "bram_last");
      drive_i(32'h4000);
      push_exp(1'b0, 3'b000, 32'h4000, 32'h0, 4'h0);
      wait_resp(2, "bram_top");
      drive_d(32'h0010_0004, 32'h0, 4'h0);
      push_exp(1'b1, 3'b000, 32'h0010_0004, 32'h0, 4'h0);
      wait_resp(2, "uart_top");
      lat = 3;
      drive_i(32'h0010_0003);
      push_exp(1'b0, 3'b010, 32'h0010_0003, 32'h0, 4'h0);
      wait_resp(4, "uart_slow");

      // reset while BUSY with an imem request pending
      lat = 6;
      drive_d(32'h40, 32'h0, 4'h0);
      step();
      step();
      drive_i(32'h44);
      step();
      reset = 1'b0;
      #1;
      chk("reset_mid_busy", {imem_rdata, imem_ready, dmem_rdata, dmem_ready, slave_valid,
                             slave_addr, slave_wdata, slave_wstrb, bus_error}, '0);
      step();
      step();
      chk("reset_held", {imem_rdata, imem_ready, dmem_rdata, dmem_ready, slave_valid,
                         slave_addr, slave_wdata, slave_wstrb, bus_error}, '0);
      reset = 1'b1;
      quiet = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         quiet += int'(imem_ready) + int'(dmem_ready) + int'(bus_error) + int'(slave_valid != 3'b000);
      end
      chk("no_replay", quiet, 0);

      lat = 1;
      drive_i(32'h8);
      push_exp(1'b0, 3'b001, 32'h8, 32'h0, 4'h0);
      wait_resp(2, "post_reset");
      drive_i(32'h30);
      drive_d(32'h34, 32'h0, 4'h0);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      push_exp(1'b1, 3'b001, 32'h34, 32'h0, 4'h0);
      push_exp(1'b0, 3'b001, 32'h30, 32'h0, 4'h0);
`else
      push_exp(1'b1, 3'b001, 32'h34, 32'h0, 4'h0);
      push_exp(1'b0, 3'b001, 32'h30, 32'h0, 4'h0);
`endif
      wait_resp(2, "post_tie_a");
      wait_resp(2, "post_tie_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
